// File: rtl/rf_wb_arbiter.sv
// -----------------------------------------------------------------------------
// rf_wb_arbiter
//
// Shares the register file's single write port between two writeback sources:
// the single-cycle ALU path (port 0) and the multi-cycle load/mul unit (port 1).
// Grants are round-robin on ties, and the winning request is registered one
// stage before it reaches the register file. A per-register pending-write
// bitmap (busy) is also kept here so that the issue stage can stall on RAW
// hazards. Register x0 is never written and is never marked busy.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   wb0_valid/addr/data      port 0 write request
//   wb0_ready                port 0 granted this cycle (combinational)
//   wb1_valid/addr/data      port 1 write request
//   wb1_ready                port 1 granted this cycle (combinational)
//   claim_valid/claim_addr   issue stage marks a destination as pending
//   RegWEn/AddrD/DataD       registered register-file write port
//   busy                     pending-write bitmap, bit i = register i
// -----------------------------------------------------------------------------
module rf_wb_arbiter #(
  parameter int RAWIDTH = 5,
  parameter int DWIDTH  = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wb0_valid,
  input  logic [RAWIDTH-1:0]      wb0_addr,
  input  logic [DWIDTH-1:0]       wb0_data,
  output logic                    wb0_ready,
  input  logic                    wb1_valid,
  input  logic [RAWIDTH-1:0]      wb1_addr,
  input  logic [DWIDTH-1:0]       wb1_data,
  output logic                    wb1_ready,
  input  logic                    claim_valid,
  input  logic [RAWIDTH-1:0]      claim_addr,
  output logic                    RegWEn,
  output logic [RAWIDTH-1:0]      AddrD,
  output logic [DWIDTH-1:0]       DataD,
  output logic [2**RAWIDTH-1:0]   busy
);

  localparam int NREG = 2**RAWIDTH;

  // 1 means port 1 was granted most recently; resets to 1 so port 0 wins the
  // first tie.
  logic                r_last_grant;

  logic                w_gnt0;
  logic                w_gnt1;
  logic                w_xfer;
  logic [RAWIDTH-1:0]  w_addr;
  logic [DWIDTH-1:0]   w_data;
  logic [NREG-1:0]     w_busy_nxt;

  // A lone requester always wins; on a tie the port not granted last wins.
  assign w_gnt0 = wb0_valid && (!wb1_valid || r_last_grant);
  assign w_gnt1 = wb1_valid && (!wb0_valid || !r_last_grant);
  assign w_xfer = w_gnt0 || w_gnt1;
  assign w_addr = w_gnt1 ? wb1_addr : wb0_addr;
  assign w_data = w_gnt1 ? wb1_data : wb0_data;

  assign wb0_ready = w_gnt0;
  assign wb1_ready = w_gnt1;

  // Scoreboard next state: the clear follows the register file commit (the
  // edge where RegWEn is high), and a same-edge claim overrides the clear.
  always_comb begin
    // NOTE: assigning the whole vector first keeps every bit driven on every
    // path, so no latch is inferred for the bits the ifs below do not touch.
    w_busy_nxt = busy;
    if (RegWEn) begin
      w_busy_nxt[AddrD] = 1'b0;
    end
    if (claim_valid && (claim_addr != '0)) begin
      w_busy_nxt[claim_addr] = 1'b1;
    end
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_grant <= 1'b1;
      RegWEn       <= 1'b0;
      AddrD        <= '0;
      DataD        <= '0;
      busy         <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values;
      // the busy clear above relies on seeing the old RegWEn/AddrD.
      RegWEn <= w_xfer && (w_addr != '0);
      busy   <= w_busy_nxt;
      if (w_xfer) begin
        r_last_grant <= w_gnt1;
        AddrD        <= w_addr;
        DataD        <= w_data;
      end
    end
  end

endmodule
